quadrature_mul_acc_windowed: RTL and testbench

Next-generation dual quadrature multiply-accumulate for the sensor front end. Sums SIN_VALUE*ADC_VALUE and COS_VALUE*ADC_VALUE over windows of a whole number of ADC periods, delimited by rising zero crossings. Emits one registered result per window: both sums, the sample count and a valid strobe. Sits between the DCO sin/cos table and the phase/amplitude calculation logic, which no longer has to difference free-running accumulators.

---
 rtl/quadrature_mul_acc_windowed.sv | 189 ++++++++++++++++++
 tb/tb_quadrature_mul_acc_windowed.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_mul_acc_windowed.sv
// Windowed sin/cos x ADC multiply-accumulate; windows are whole ADC periods bounded by rising zero crossings.
// Optional macro QMAC_ZC_HYSTERESIS_EN qualifies crossings with a +/-HYST_THRESHOLD hysteresis band.
module quadrature_mul_acc_windowed #(
    parameter int SIN_TABLE_DATA_WIDTH = 13,
    parameter int ADC_DATA_WIDTH       = 12,
    parameter int COUNTER_WIDTH        = 16,
    parameter int PERIODS_WIDTH        = 8,
    parameter int RESULT_WIDTH         = 48,
    parameter int HYST_THRESHOLD       = 16
) (
    input  logic                                   CLK,
    input  logic                                   RESET,
    input  logic                                   CE,
    input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] SIN_VALUE,
    input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] COS_VALUE,
    input  logic signed [ADC_DATA_WIDTH-1:0]       ADC_VALUE,
    input  logic        [PERIODS_WIDTH-1:0]        PERIODS,
    output logic signed [RESULT_WIDTH-1:0]         SIN_SUM,
    output logic signed [RESULT_WIDTH-1:0]         COS_SUM,
    output logic        [COUNTER_WIDTH-1:0]        SAMPLE_COUNT,
    output logic                                   OUT_TIMEOUT,
    output logic                                   OUT_VALID
);
    localparam int PROD_W = SIN_TABLE_DATA_WIDTH + ADC_DATA_WIDTH;
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

    if (RESULT_WIDTH < PROD_W + COUNTER_WIDTH || HYST_THRESHOLD < 0) begin : g_bad_params
        $error("quadrature_mul_acc_windowed: RESULT_WIDTH too small or negative HYST_THRESHOLD");
    end

    logic signed [SIN_TABLE_DATA_WIDTH-1:0] r_sin_p0, r_cos_p0;
    logic signed [ADC_DATA_WIDTH-1:0]       r_adc_p0;
    logic                                   r_zc_p0;
    logic                                   w_zc;

`ifdef QMAC_ZC_HYSTERESIS_EN
    localparam logic signed [ADC_DATA_WIDTH-1:0] HYST_POS = ADC_DATA_WIDTH'(HYST_THRESHOLD);
    localparam logic signed [ADC_DATA_WIDTH-1:0] HYST_NEG = ADC_DATA_WIDTH'(-HYST_THRESHOLD);
    logic r_armed;

    assign w_zc = r_armed && (ADC_VALUE >= HYST_POS);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_armed <= 1'b0;
        end else if (CE) begin
            if (ADC_VALUE <= HYST_NEG) begin
                r_armed <= 1'b1;
            end else if (w_zc) begin
                r_armed <= 1'b0;
            end
        end
    end
`else
    assign w_zc = r_adc_p0[ADC_DATA_WIDTH-1] && !ADC_VALUE[ADC_DATA_WIDTH-1];
`endif

    // Stage 0: input capture; zc flags the sample being loaded into r_adc_p0
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sin_p0 <= '0;
            r_cos_p0 <= '0;
            r_adc_p0 <= '0;
            r_zc_p0  <= 1'b0;
        end else if (CE) begin
            r_sin_p0 <= SIN_VALUE;
            r_cos_p0 <= COS_VALUE;
            r_adc_p0 <= ADC_VALUE;
            r_zc_p0  <= w_zc;
        end
    end

    logic signed [PROD_W-1:0] r_psin_p1, r_pcos_p1;
    logic                     r_zc_p1;

    // Stage 1: full-precision signed products
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_psin_p1 <= '0;
            r_pcos_p1 <= '0;
            r_zc_p1   <= 1'b0;
        end else if (CE) begin
            r_psin_p1 <= PROD_W'(r_sin_p0) * PROD_W'(r_adc_p0);
            r_pcos_p1 <= PROD_W'(r_cos_p0) * PROD_W'(r_adc_p0);
            r_zc_p1   <= r_zc_p0;
        end
    end

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                           r_state, w_state_nxt;
    logic signed [RESULT_WIDTH-1:0]   r_acc_sin, r_acc_cos, w_acc_sin_nxt, w_acc_cos_nxt;
    logic signed [RESULT_WIDTH-1:0]   w_psin_ext, w_pcos_ext;
    logic        [COUNTER_WIDTH-1:0]  r_count, w_count_nxt;
    logic        [PERIODS_WIDTH-1:0]  r_xcount, w_xcount_nxt, r_target, w_target_nxt, w_periods_min1;
    logic                             w_close, w_timeout;

    assign w_psin_ext     = RESULT_WIDTH'(r_psin_p1);
    assign w_pcos_ext     = RESULT_WIDTH'(r_pcos_p1);
    assign w_periods_min1 = (PERIODS == '0) ? PERIODS_WIDTH'(1) : PERIODS;

    // Stage 2: window control; a closing sample always seeds the next window
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_sin_nxt = r_acc_sin;
        w_acc_cos_nxt = r_acc_cos;
        w_count_nxt   = r_count;
        w_xcount_nxt  = r_xcount;
        w_target_nxt  = r_target;
        w_close       = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_zc_p1) begin
                    w_state_nxt   = ST_RUN;
                    w_acc_sin_nxt = w_psin_ext;
                    w_acc_cos_nxt = w_pcos_ext;
                    w_count_nxt   = COUNTER_WIDTH'(1);
                    w_xcount_nxt  = '0;
                    w_target_nxt  = w_periods_min1;
                end
            end
            ST_RUN: begin
                if (r_zc_p1 && (r_xcount + PERIODS_WIDTH'(1) == r_target)) begin
                    w_close       = 1'b1;
                    w_acc_sin_nxt = w_psin_ext;
                    w_acc_cos_nxt = w_pcos_ext;
                    w_count_nxt   = COUNTER_WIDTH'(1);
                    w_xcount_nxt  = '0;
                    w_target_nxt  = w_periods_min1;
                end else if (r_zc_p1) begin
                    w_xcount_nxt  = r_xcount + PERIODS_WIDTH'(1);
                    w_acc_sin_nxt = r_acc_sin + w_psin_ext;
                    w_acc_cos_nxt = r_acc_cos + w_pcos_ext;
                    w_count_nxt   = r_count + COUNTER_WIDTH'(1);
                end else if (r_count == CNT_MAX) begin
                    w_close       = 1'b1;
                    w_timeout     = 1'b1;
                    w_acc_sin_nxt = w_psin_ext;
                    w_acc_cos_nxt = w_pcos_ext;
                    w_count_nxt   = COUNTER_WIDTH'(1);
                end else begin
                    w_acc_sin_nxt = r_acc_sin + w_psin_ext;
                    w_acc_cos_nxt = r_acc_cos + w_pcos_ext;
                    w_count_nxt   = r_count + COUNTER_WIDTH'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_acc_sin <= '0;
            r_acc_cos <= '0;
            r_count   <= '0;
            r_xcount  <= '0;
            r_target  <= '0;
        end else if (CE) begin
            r_state   <= w_state_nxt;
            r_acc_sin <= w_acc_sin_nxt;
            r_acc_cos <= w_acc_cos_nxt;
            r_count   <= w_count_nxt;
            r_xcount  <= w_xcount_nxt;
            r_target  <= w_target_nxt;
        end
    end

    // Result registers; OUT_VALID is rewritten every CLK so it never outlasts one cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            SIN_SUM      <= '0;
            COS_SUM      <= '0;
            SAMPLE_COUNT <= '0;
            OUT_TIMEOUT  <= 1'b0;
            OUT_VALID    <= 1'b0;
        end else begin
            OUT_VALID <= CE && w_close;
            if (CE && w_close) begin
                SIN_SUM      <= r_acc_sin;
                COS_SUM      <= r_acc_cos;
                SAMPLE_COUNT <= r_count;
                OUT_TIMEOUT  <= w_timeout;
            end
        end
    end

endmodule

// File: tb/tb_quadrature_mul_acc_windowed.sv
// Directed bench for quadrature_mul_acc_windowed: a 16-bit-counter instance plus a 4-bit-counter instance for timeouts.
module tb_quadrature_mul_acc_windowed;
    localparam int SW = 13;
    localparam int AW = 12;
    localparam int PW = 8;
    localparam int RW = 48;

    logic                 CLK, RESET, CE;
    logic signed [SW-1:0] sin_v, cos_v;
    logic signed [AW-1:0] adc_v;
    logic        [PW-1:0] per_v;

    logic signed [RW-1:0] m_sin, m_cos, t_sin, t_cos;
    logic        [15:0]   m_cnt;
    logic        [3:0]    t_cnt;
    logic                 m_to, m_vld, t_to, t_vld;

    quadrature_mul_acc_windowed #(.SIN_TABLE_DATA_WIDTH(SW), .ADC_DATA_WIDTH(AW), .COUNTER_WIDTH(16),
        .PERIODS_WIDTH(PW), .RESULT_WIDTH(RW), .HYST_THRESHOLD(16)) dut (
        .CLK(CLK), .RESET(RESET), .CE(CE), .SIN_VALUE(sin_v), .COS_VALUE(cos_v), .ADC_VALUE(adc_v),
        .PERIODS(per_v), .SIN_SUM(m_sin), .COS_SUM(m_cos), .SAMPLE_COUNT(m_cnt),
        .OUT_TIMEOUT(m_to), .OUT_VALID(m_vld));

    quadrature_mul_acc_windowed #(.SIN_TABLE_DATA_WIDTH(SW), .ADC_DATA_WIDTH(AW), .COUNTER_WIDTH(4),
        .PERIODS_WIDTH(PW), .RESULT_WIDTH(RW), .HYST_THRESHOLD(16)) dut_t (
        .CLK(CLK), .RESET(RESET), .CE(CE), .SIN_VALUE(sin_v), .COS_VALUE(cos_v), .ADC_VALUE(adc_v),
        .PERIODS(per_v), .SIN_SUM(t_sin), .COS_SUM(t_cos), .SAMPLE_COUNT(t_cnt),
        .OUT_TIMEOUT(t_to), .OUT_VALID(t_vld));

    typedef struct {
        longint s;
        longint c;
        int     n;
        bit     to;
        int     idx;
    } win_t;

    win_t wq[$];
    win_t tq[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   ce_edges = 0;
    int   long_pulse = 0;
    bit   prev_valid = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One CLK cycle: drive inputs, wait for the edge, log any window reported by either instance
    task automatic apply(input int a, input int s, input int c, input int p, input bit ce);
        adc_v = AW'(a);
        sin_v = SW'(s);
        cos_v = SW'(c);
        per_v = PW'(p);
        CE    = ce;
        @(posedge CLK);
        #1;
        if (m_vld) wq.push_back('{longint'(m_sin), longint'(m_cos), int'(m_cnt), m_to, ce_edges});
        if (m_vld && prev_valid) long_pulse++;
        prev_valid = m_vld;
        if (t_vld) tq.push_back('{longint'(t_sin), longint'(t_cos), int'(t_cnt), t_to, ce_edges});
        if (ce) ce_edges++;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        apply(0, 0, 0, 1, 1'b1);
        apply(0, 0, 0, 1, 1'b1);
        RESET = 1'b0;
        ce_edges = 0;
        wq.delete();
        tq.delete();
        prev_valid = 1'b0;
        long_pulse = 0;
    endtask

    function automatic int pat(input int i);
        return ((i % 4) < 2) ? -100 : 200;
    endfunction

    // Periodic [-100,-100,200,200] with SIN=10, COS=-5; optional random CE-low gaps between samples
    task automatic run_periodic(input string tag, input int per, input bit ce_rand, input int nsamp,
                                input int len, input int first);
        int nexp;
        for (int i = 0; i < nsamp; i++) begin
            if (ce_rand) begin
                int gaps = int'($urandom_range(0, 2));
                for (int g = 0; g < gaps; g++)
                    apply(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 100)), 7, 5, 1'b0);
            end
            apply(pat(i), 10, -5, per, 1'b1);
        end
        nexp = (nsamp - 1 - first) / len + 1;
        n_vec++;
        if (wq.size() != nexp) begin
            n_fail++;
            $display("FAIL %s window_count: got %0d, expected %0d", tag, wq.size(), nexp);
        end
        for (int k = 0; k < wq.size() && k < nexp; k++) begin
            longint es = longint'(len / 4) * 2000;
            longint ec = -longint'(len / 4) * 1000;
            int     ei = first + k * len;
            n_vec++;
            if (wq[k].s != es || wq[k].c != ec || wq[k].n != len || wq[k].to != 1'b0 || wq[k].idx != ei) begin
                n_fail++;
                $display("FAIL %s win%0d: sin=%0d cos=%0d n=%0d to=%0d at=%0d, expected %0d %0d %0d 0 %0d",
                         tag, k, wq[k].s, wq[k].c, wq[k].n, wq[k].to, wq[k].idx, es, ec, len, ei);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({m_sin, m_cos, m_cnt, m_to, m_vld} !== '0) begin
            n_fail++;
            $display("FAIL reset_main: sin=%0d cos=%0d n=%0d to=%b vld=%b, expected all 0", m_sin, m_cos, m_cnt, m_to, m_vld);
        end
        n_vec++;
        if ({t_sin, t_cos, t_cnt, t_to, t_vld} !== '0) begin
            n_fail++;
            $display("FAIL reset_t: sin=%0d cos=%0d n=%0d to=%b vld=%b, expected all 0", t_sin, t_cos, t_cnt, t_to, t_vld);
        end
    endtask

    task automatic test_basic();
        do_reset();
        run_periodic("periods1", 1, 1'b0, 34, 4, 8);
    endtask

    task automatic test_periods();
        do_reset();
        run_periodic("periods3", 3, 1'b0, 42, 12, 16);
        do_reset();
        run_periodic("periods0", 0, 1'b0, 34, 4, 8);
    endtask

    task automatic test_ce_gating();
        do_reset();
        run_periodic("ce_toggle", 1, 1'b1, 34, 4, 8);
        n_vec++;
        if (long_pulse != 0) begin
            n_fail++;
            $display("FAIL ce_valid_width: %0d multi-cycle OUT_VALID pulses, expected 0", long_pulse);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 14; i++) apply(pat(i), 10, -5, 1, 1'b1);
        RESET = 1'b1;
        apply(pat(14), 10, -5, 1, 1'b1);
        n_vec++;
        if ({m_sin, m_cos, m_cnt, m_to, m_vld} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: sin=%0d cos=%0d n=%0d to=%b vld=%b, expected all 0", m_sin, m_cos, m_cnt, m_to, m_vld);
        end
        RESET = 1'b0;
        ce_edges = 0;
        wq.delete();
        tq.delete();
        prev_valid = 1'b0;
        run_periodic("after_midreset", 1, 1'b0, 34, 4, 8);
    endtask

    task automatic test_timeout();
        do_reset();
        apply(-50, 10, -5, 1, 1'b1);
        for (int i = 1; i < 50; i++) apply(50, 10, -5, 1, 1'b1);
        n_vec++;
        if (tq.size() != 3) begin
            n_fail++;
            $display("FAIL timeout_count: got %0d windows, expected 3", tq.size());
        end
        for (int k = 0; k < tq.size() && k < 3; k++) begin
            n_vec++;
            if (tq[k].s != 7500 || tq[k].c != -3750 || tq[k].n != 15 || tq[k].to != 1'b1 || tq[k].idx != 18 + 15 * k) begin
                n_fail++;
                $display("FAIL timeout_win%0d: sin=%0d cos=%0d n=%0d to=%0d at=%0d, expected 7500 -3750 15 1 %0d",
                         k, tq[k].s, tq[k].c, tq[k].n, tq[k].to, tq[k].idx, 18 + 15 * k);
            end
        end
        n_vec++;
        if (wq.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_wide_counter: got %0d windows, expected 0", wq.size());
        end
    endtask

    // Period [-200,3,-2,200]: the small dither crosses zero but never leaves the +/-16 band
    task automatic test_dither();
        int nexp, len, first;
        do_reset();
        for (int i = 0; i < 26; i++) begin
            int a;
            case (i % 4)
                0: a = -200;
                1: a = 3;
                2: a = -2;
                default: a = 200;
            endcase
            apply(a, 10, -5, 1, 1'b1);
        end
`ifdef QMAC_ZC_HYSTERESIS_EN
        nexp = 5; len = 4; first = 9;
`else
        nexp = 11; len = 2; first = 5;
`endif
        n_vec++;
        if (wq.size() != nexp) begin
            n_fail++;
            $display("FAIL dither_count: got %0d windows, expected %0d", wq.size(), nexp);
        end
        for (int k = 0; k < wq.size() && k < nexp; k++) begin
            longint es = (len == 4 || k % 2 == 0) ? 10 : 0;
            longint ec = (len == 4 || k % 2 == 0) ? -5 : 0;
            int     ei = first + k * len;
            n_vec++;
            if (wq[k].s != es || wq[k].c != ec || wq[k].n != len || wq[k].to != 1'b0 || wq[k].idx != ei) begin
                n_fail++;
                $display("FAIL dither_win%0d: sin=%0d cos=%0d n=%0d to=%0d at=%0d, expected %0d %0d %0d 0 %0d",
                         k, wq[k].s, wq[k].c, wq[k].n, wq[k].to, wq[k].idx, es, ec, len, ei);
            end
        end
    endtask

    initial begin
        RESET = 1'b1;
        CE    = 1'b0;
        adc_v = '0;
        sin_v = '0;
        cos_v = '0;
        per_v = '0;
        test_reset();
        test_basic();
        test_periods();
        test_ce_gating();
        test_reset_mid();
        test_timeout();
        test_dither();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
